// File: rtl/stage_fetch_if.sv
// Fetch-stage bundle: hazard controls, imem request/response, decode outputs.
// Latency: none, wires only.
// Backpressure: none here; fe_stall/imem_rvalid are carried to the fetch stage.
interface stage_fetch_if;
  logic        fe_stall;
  logic        de_flush;
  logic        ex_pc_src;
  logic [31:0] ex_pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] de_instr;
  logic [31:0] de_pc;
  logic [31:0] de_pc_plus4;

  // Fetch-stage side.
  modport master (
    input  fe_stall, de_flush, ex_pc_src, ex_pc_target, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, de_instr, de_pc, de_pc_plus4
  );

  // Environment side: hazard unit, execute redirect, instruction memory, decode.
  modport slave (
    output fe_stall, de_flush, ex_pc_src, ex_pc_target, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, de_instr, de_pc, de_pc_plus4
  );
endinterface

// File: rtl/stage_fetch.sv
// Instruction fetch: owns the PC, single-outstanding imem requests, decode regs.
// Latency: request edge N, 1-cycle memory, instruction on de_* after edge N+2.
// Backpressure: fe_stall freezes decode regs; one early response is buffered.
module stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  stage_fetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] de_instr_q, de_instr_d;
  logic [31:0] de_pc_q, de_pc_d;
  logic [31:0] de_pc_plus4_q, de_pc_plus4_d;

  logic        req;
  logic [31:0] addr;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = bus.ex_pc_target & 32'hFFFF_FFFC;

  // Sequencing: redirect always wins; a stalled response parks in hold_q.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_d        = hold_q;
    req           = 1'b0;
    addr          = pc_q;
    deliver       = 1'b0;
    deliver_instr = hold_q;
    unique case (state_q)
      ST_FETCH: begin
        if (bus.ex_pc_src) begin
          pc_d = redirect_pc;
        end else begin
          req     = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.ex_pc_src) begin
          pc_d    = redirect_pc;
          // A response arriving with the redirect is stale and simply dropped.
          state_d = bus.imem_rvalid ? ST_FETCH : ST_DROP;
        end else if (bus.imem_rvalid) begin
          if (bus.fe_stall) begin
            hold_d  = bus.imem_rdata;
            state_d = ST_HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = bus.imem_rdata;
            req           = 1'b1;
            addr          = pc_plus4;
            pc_d          = pc_plus4;
          end
        end
      end
      ST_HOLD: begin
        if (bus.ex_pc_src) begin
          pc_d    = redirect_pc;
          state_d = ST_FETCH;
        end else if (!bus.fe_stall) begin
          deliver       = 1'b1;
          deliver_instr = hold_q;
          req           = 1'b1;
          addr          = pc_plus4;
          pc_d          = pc_plus4;
          state_d       = ST_WAIT;
        end
      end
      ST_DROP: begin
        // Newest redirect wins while the stale response is still in flight.
        if (bus.ex_pc_src) begin
          pc_d = redirect_pc;
        end
        if (bus.imem_rvalid) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Decode registers: flush beats stall beats delivery; otherwise a bubble.
  always_comb begin
    de_instr_d    = NOP_INSTR;
    de_pc_d       = 32'd0;
    de_pc_plus4_d = 32'd0;
    if (bus.de_flush) begin
      de_instr_d    = NOP_INSTR;
      de_pc_d       = 32'd0;
      de_pc_plus4_d = 32'd0;
    end else if (bus.fe_stall) begin
      de_instr_d    = de_instr_q;
      de_pc_d       = de_pc_q;
      de_pc_plus4_d = de_pc_plus4_q;
    end else if (deliver) begin
      de_instr_d    = deliver_instr;
      de_pc_d       = pc_q;
      de_pc_plus4_d = pc_plus4;
    end
  end

  // State and pipeline registers; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC & 32'hFFFF_FFFC;
      hold_q        <= 32'd0;
      de_instr_q    <= NOP_INSTR;
      de_pc_q       <= 32'd0;
      de_pc_plus4_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_q        <= hold_d;
      de_instr_q    <= de_instr_d;
      de_pc_q       <= de_pc_d;
      de_pc_plus4_q <= de_pc_plus4_d;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = addr;
  assign bus.de_instr    = de_instr_q;
  assign bus.de_pc       = de_pc_q;
  assign bus.de_pc_plus4 = de_pc_plus4_q;

endmodule

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: directed scenarios plus random stalls/flushes/redirects.
// Reference keeps an in-flight/stale/buffered view of fetch, not the RTL states.
// Memory model answers each request after a programmable 1..3 cycle latency.
module tb_stage_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stage_fetch_if bus();

  stage_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // memory model
  bit          m_pend;
  int          m_cnt;
  logic [31:0] m_addr;
  int          lat_min, lat_max;

  // reference model
  logic [31:0] md_pc, md_hold;
  bit          md_out, md_stale, md_buf;
  logic [31:0] md_de_instr, md_de_pc, md_de_pc4;

  logic [31:0] req_log[$];
  bit          last_req;

  task automatic model_reset();
    md_pc = RST_PC; md_hold = 32'd0;
    md_out = 0; md_stale = 0; md_buf = 0;
    md_de_instr = NOP; md_de_pc = 32'd0; md_de_pc4 = 32'd0;
    m_pend = 0; m_cnt = 0; m_addr = 32'd0;
  endtask

  task automatic cyc(input bit stall, input bit flush, input bit redir, input logic [31:0] tgt);
    bit          rv, e_req, dlv;
    logic [31:0] rd, e_addr, dinstr, dpc, al;
    @(negedge clk);
    rv = m_pend && (m_cnt == 1);
    rd = m_addr ^ KEY;
    bus.fe_stall     = stall;
    bus.de_flush     = flush;
    bus.ex_pc_src    = redir;
    bus.ex_pc_target = tgt;
    bus.imem_rvalid  = rv;
    bus.imem_rdata   = rv ? rd : 32'hDEAD_BEEF;
    #1;
    al = tgt & 32'hFFFF_FFFC;
    e_req = 0; e_addr = md_pc; dlv = 0; dinstr = 32'd0; dpc = md_pc;
    if (!md_out && !md_buf) begin
      if (redir) md_pc = al;
      else begin e_req = 1; e_addr = md_pc; md_out = 1; end
    end else if (md_buf) begin
      if (redir) begin md_buf = 0; md_pc = al; end
      else if (!stall) begin
        dlv = 1; dinstr = md_hold; dpc = md_pc;
        e_req = 1; e_addr = md_pc + 32'd4; md_pc = md_pc + 32'd4;
        md_buf = 0; md_out = 1;
      end
    end else if (md_stale) begin
      if (redir) md_pc = al;
      if (rv) begin md_out = 0; md_stale = 0; end
    end else begin
      if (redir) begin
        md_pc = al;
        if (rv) md_out = 0; else md_stale = 1;
      end else if (rv) begin
        if (stall) begin md_buf = 1; md_hold = rd; md_out = 0; end
        else begin
          dlv = 1; dinstr = rd; dpc = md_pc;
          e_req = 1; e_addr = md_pc + 32'd4; md_pc = md_pc + 32'd4;
        end
      end
    end
    chk("imem_req", 32'(bus.imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", bus.imem_addr, e_addr);
    last_req = bus.imem_req;
    if (bus.imem_req) req_log.push_back(bus.imem_addr);
    if (rv) m_pend = 0;
    else if (m_pend) m_cnt--;
    if (bus.imem_req) begin
      m_pend = 1;
      m_cnt  = $urandom_range(lat_min, lat_max);
      m_addr = bus.imem_addr;
    end
    if (flush) begin
      md_de_instr = NOP; md_de_pc = 32'd0; md_de_pc4 = 32'd0;
    end else if (!stall) begin
      if (dlv) begin md_de_instr = dinstr; md_de_pc = dpc; md_de_pc4 = dpc + 32'd4; end
      else begin md_de_instr = NOP; md_de_pc = 32'd0; md_de_pc4 = 32'd0; end
    end
    @(posedge clk);
    #1;
    chk("de_instr", bus.de_instr, md_de_instr);
    chk("de_pc", bus.de_pc, md_de_pc);
    chk("de_pc_plus4", bus.de_pc_plus4, md_de_pc4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt300, seen_wrap;
    rst = 1'b1;
    bus.fe_stall = 0; bus.de_flush = 0; bus.ex_pc_src = 0;
    bus.ex_pc_target = 32'd0; bus.imem_rvalid = 0; bus.imem_rdata = 32'd0;
    lat_min = 1; lat_max = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_de_instr", bus.de_instr, NOP);
    chk("rst_de_pc", bus.de_pc, 32'd0);
    chk("rst_de_pc_plus4", bus.de_pc_plus4, 32'd0);
    rst = 1'b0;
    #1;
    chk("release_req", 32'(bus.imem_req), 32'd1);
    chk("release_addr", bus.imem_addr, RST_PC);

    // steady stream, then a 3-cycle stall as the 0x108 response lands
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("first_de_pc", bus.de_pc, 32'h100);
    cyc(0, 0, 0, 0);
    chk("second_de_pc", bus.de_pc, 32'h104);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("held_de_pc", bus.de_pc, 32'h108);
    chk("held_de_instr", bus.de_instr, 32'h108 ^ KEY);
    chk("req_count", 32'(req_log.size()), 32'd4);
    chk("req_seq0", req_log[0], 32'h100);
    chk("req_seq1", req_log[1], 32'h104);
    chk("req_seq2", req_log[2], 32'h108);
    chk("req_seq3", req_log[3], 32'h10C);
    repeat (5) cyc(0, 0, 0, 0);

    // redirect to 0x2002 in WAIT with a 3-cycle memory
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      if (last_req) break;
    end
    cyc(0, 0, 1, 32'h2002);
    n = req_log.size();
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 0, 0);
      if (bus.de_pc == 32'h2000) break;
      chk("bubble_after_redirect", bus.de_instr, NOP);
    end
    chk("redirect_first_req", (req_log.size() > n) ? req_log[n] : 32'hDEAD_BEEF, 32'h2000);
    chk("redirect_reach_pc", bus.de_pc, 32'h2000);
    chk("redirect_reach_instr", bus.de_instr, 32'h2000 ^ KEY);

    // two redirects while dropping a stale response
    for (int i = 0; i < 10 && !last_req; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h300);
    cyc(0, 0, 1, 32'h400);
    n = req_log.size();
    repeat (8) cyc(0, 0, 0, 0);
    chk("drop_first_req", (req_log.size() > n) ? req_log[n] : 32'hDEAD_BEEF, 32'h400);
    cnt300 = 0;
    for (int i = n; i < req_log.size(); i++) if (req_log[i] == 32'h300) cnt300++;
    chk("drop_no_0x300", 32'(cnt300), 32'd0);

    // flush and stall together
    cyc(1, 1, 0, 0);
    chk("flush_stall_instr", bus.de_instr, NOP);
    chk("flush_stall_pc", bus.de_pc, 32'd0);
    chk("flush_stall_pc4", bus.de_pc_plus4, 32'd0);

    // PC wrap at the top of the address space
    lat_min = 1; lat_max = 1;
    n = req_log.size();
    cyc(0, 0, 1, 32'hFFFF_FFFE);
    seen_wrap = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0);
      if (bus.de_pc == 32'hFFFF_FFFC) begin
        seen_wrap = 1;
        chk("wrap_pc_plus4", bus.de_pc_plus4, 32'd0);
      end
    end
    chk("wrap_seen", 32'(seen_wrap), 32'd1);
    for (int i = n; i + 1 < req_log.size(); i++) begin
      if (req_log[i] == 32'hFFFF_FFFC) begin
        chk("wrap_next_addr", req_log[i + 1], 32'd0);
        break;
      end
    end

    // random traffic
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 12) == 0, $urandom);
    end

    // asynchronous reset with a request outstanding
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      if (last_req) break;
    end
    @(negedge clk);
    bus.fe_stall = 0; bus.de_flush = 0; bus.ex_pc_src = 0; bus.imem_rvalid = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_de_instr", bus.de_instr, NOP);
    chk("arst_de_pc", bus.de_pc, 32'd0);
    chk("arst_de_pc_plus4", bus.de_pc_plus4, 32'd0);
    chk("arst_req", 32'(bus.imem_req), 32'd1);
    chk("arst_addr", bus.imem_addr, RST_PC);
    model_reset();
    lat_min = 1; lat_max = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) cyc(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/stage_fetch.md
# stage_fetch

Instruction-fetch stage of the 5-stage core, directly upstream of the decode stage. It owns the program counter and talks to instruction memory over a single-outstanding request/response interface. It holds prefetched instructions across hazard-unit stalls, drops stale responses after a taken jump or branch from execute, and drives the registered fetch/decode pipeline outputs `de_instr`, `de_pc` and `de_pc_plus4`.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0000: bubble word. It must decode with reg_write = 0 and mem_write = 0.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fe_stall`  in  1  from hazard unit; freezes the decode registers.
- `de_flush`  in  1  from hazard unit; loads a bubble into the decode registers.
- `ex_pc_src`  in  1  redirect request; a taken jump or branch resolved in execute.
- `ex_pc_target`  in  32  redirect target.
- `imem_req`  out  1  request strobe; the request is accepted on the same edge.
- `imem_addr`  out  32  request address; always word-aligned.
- `imem_rvalid`  in  1  response valid; arrives 1 or more cycles after the request.
- `imem_rdata`  in  32  response instruction.
- `de_instr`  out  32  registered instruction to decode.
- `de_pc`  out  32  registered PC of `de_instr`.
- `de_pc_plus4`  out  32  registered `de_pc + 4`.

## Operation
- Internal state:
  - `pc_q` (32): address of the instruction currently requested or held.
  - `hold_q` (32): stall buffer.
  - FSM: FETCH, WAIT, HOLD, DROP.
- Redirect (`ex_pc_src` = 1): `pc_q <= {ex_pc_target[31:2], 2'b00}`. No delivery happens that cycle. If both the memory and a redirect are active, the redirect wins.
- `deliver` is asserted when either:
  - state is WAIT and `imem_rvalid` = 1 and `fe_stall` = 0 and no redirect, or
  - state is HOLD and `fe_stall` = 0 and no redirect.
- FSM transitions and outputs:
  - FETCH, no redirect: `imem_req` = 1, `imem_addr` = `pc_q`, next state WAIT. This issues even while `fe_stall` is high.
  - FETCH, redirect: `imem_req` = 0, stay in FETCH.
  - WAIT, no `imem_rvalid`:
    - no redirect: stay in WAIT.
    - redirect: go to DROP.
  - WAIT, `imem_rvalid`, redirect: discard the response, go to FETCH.
  - WAIT, `imem_rvalid`, `fe_stall`: `hold_q <= imem_rdata`, go to HOLD.
  - WAIT, deliver: the response goes to decode. Same cycle `imem_req` = 1, `imem_addr` = `pc_q + 4`, `pc_q <= pc_q + 4`, stay in WAIT.
  - HOLD, `fe_stall`: stay in HOLD.
  - HOLD, redirect: discard `hold_q`, go to FETCH.
  - HOLD, deliver: `hold_q` goes to decode. Issue `pc_q + 4`, `pc_q <= pc_q + 4`, go to WAIT.
  - DROP: `imem_req` = 0. A further redirect overwrites `pc_q` (newest wins). When `imem_rvalid` arrives, discard it and go to FETCH.
- Decode register update, in priority order:
  1. `de_flush`: load `NOP_INSTR`, 0, 0.
  2. `fe_stall`: hold current values.
  3. `deliver`: load the instruction (response or `hold_q`), `pc_q`, `pc_q + 4`.
  4. Otherwise: load `NOP_INSTR`, 0, 0.
- Arithmetic: all PC adds are 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Memory contract:
  - At most one request is outstanding.
  - `imem_rvalid` never occurs without an outstanding request.
  - A response in the same cycle as a new request belongs to the previous request.

## Timing
- Reset values:
  - state = FETCH, `pc_q` = `RESET_PC`, `hold_q` = 0.
  - `de_instr` = `NOP_INSTR`, `de_pc` = 0, `de_pc_plus4` = 0.
  - `imem_req` = 1 and `imem_addr` = `RESET_PC` combinationally while in FETCH. This includes the cycle `rst` is released.
- Reset is asynchronous. Assertion mid-operation abandons any outstanding response; the next FETCH ignores a late `imem_rvalid`, which the bench must not generate.
- Latency: with a 1-cycle memory, a request at edge N gives a response in cycle N+1. That instruction appears on `de_instr` after edge N+2. Steady-state throughput is 1 instruction per cycle.
- After a redirect the target request issues 1 cycle later from FETCH, or after the stale response in DROP. The redirect penalty is 2 bubbles with a 1-cycle memory.
- `imem_req`/`imem_addr` are combinational from state, `pc_q`, `fe_stall`, `ex_pc_src` and `imem_rvalid`. The decode outputs are registered only.

## Test plan
- Reset, 1-cycle memory returning `instr = addr ^ 32'hA5A5_0000`, `RESET_PC` = 32'h100:
  - `imem_addr` sequence 0x100, 0x104, 0x108…, one per cycle.
  - `de_pc` = 0x100 two edges after release, then increments by 4 each cycle.
  - `de_pc_plus4` = `de_pc + 4`.
- `fe_stall` high for 3 cycles while the 0x108 response arrives:
  - decode outputs frozen.
  - 0x108 is buffered and delivered on the first unstalled edge.
  - no address is skipped or duplicated.
- Redirect to 0x2002 with a 3-cycle memory, asserted while in WAIT:
  - the stale response is discarded.
  - next `imem_addr` = 0x2000.
  - `de_instr` = `NOP_INSTR` until the 0x2000 instruction arrives.
- Two redirects in DROP (0x300, then 0x400): the only request issued afterwards is 0x400.
- `de_flush` and `fe_stall` both high: the decode registers load `NOP_INSTR`, 0, 0.
- `pc_q` = 32'hFFFF_FFFC delivered: next `imem_addr` = 0 and `de_pc_plus4` = 0. Asserting `rst` mid-WAIT returns all outputs to their reset values immediately.
